// File: rtl/mio_pkg.sv
// rtl/mio_pkg.sv - shared types and constants for the PCPU memory responder
package mio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } mio_state_e;

    localparam logic [31:0] GPIO_ADDR_DEFAULT = 32'hFFFF_FFFC;
    localparam int          WAIT_W            = 4;

endpackage

// File: rtl/mio_word_ram.sv
// rtl/mio_word_ram.sv - single-port DEPTH x 32 synchronous RAM with registered read data
module mio_word_ram #(
    parameter int DEPTH = 1024,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mio_mem_responder.sv
// rtl/mio_mem_responder.sv - PCPU data-port responder: word RAM, GPIO word, wait states; MIO_ERR_EN adds err
module mio_mem_responder
    import mio_pkg::*;
#(
    parameter int          DEPTH       = 1024,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] GPIO_ADDR   = GPIO_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_re,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_data,
    output logic [31:0] mem_data_in,
    output logic        MIO_ready,
    input  logic [31:0] gpio_in,
    output logic [31:0] gpio_out
`ifdef MIO_ERR_EN
    ,
    output logic        err
`endif
);

    localparam int AW = $clog2(DEPTH);

    if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15 || (1 << AW) != DEPTH) begin : g_param_check
        $error("mio_mem_responder: WAIT_CYCLES must be 0..15 and DEPTH a power of two");
    end

    mio_state_e        state_q, state_d;
    logic [WAIT_W-1:0] cnt_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic              we_q;
    logic [31:0]       gpio_q;
    logic [31:0]       hold_q;

    logic              req;
    logic              is_gpio;
    logic              bad_access;
    logic              ram_we;
    logic              ram_re;
    logic [AW-1:0]     ram_addr;
    logic [31:0]       ram_rdata;
    logic [31:0]       rd_value;

    assign req     = mem_re | mem_we;
    assign is_gpio = (addr_q == GPIO_ADDR);

`ifdef MIO_ERR_EN
    assign bad_access = !is_gpio && ((addr_q[1:0] != 2'b00) || ((addr_q >> (AW + 2)) != 32'd0));
`else
    assign bad_access = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        MIO_ready = 1'b1;
        case (state_q)
            IDLE: begin
                MIO_ready = ~req;
                if (req) begin
                    state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
                end
            end
            WAIT: begin
                MIO_ready = 1'b0;
                if (cnt_q == WAIT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                MIO_ready = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // RAM read is launched one cycle before DONE so its registered output lands in DONE
    assign ram_re   = ((state_q == IDLE) && req && (WAIT_CYCLES == 0)) ||
                      ((state_q == WAIT) && (cnt_q == WAIT_W'(1)));
    assign ram_addr = (state_q == IDLE) ? mem_addr[AW+1:2] : addr_q[AW+1:2];
    assign ram_we   = (state_q == DONE) && we_q && !is_gpio && !bad_access && !rst;

    mio_word_ram #(
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (data_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        rd_value = ram_rdata;
        if (bad_access) begin
            rd_value = 32'h0;
        end else if (is_gpio) begin
            rd_value = gpio_q;
        end
    end

    assign mem_data_in = ((state_q == DONE) && !we_q) ? rd_value : hold_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
            we_q     <= 1'b0;
            gpio_q   <= '0;
            hold_q   <= '0;
            gpio_out <= '0;
        end else begin
            state_q <= state_d;
            if ((state_q == IDLE) && req) begin
                addr_q <= mem_addr;
                data_q <= mem_data;
                we_q   <= mem_we;
                cnt_q  <= WAIT_W'(WAIT_CYCLES);
            end else if (state_q == WAIT) begin
                cnt_q <= cnt_q - WAIT_W'(1);
            end
            if ((state_d == DONE) && (state_q != DONE)) begin
                gpio_q <= gpio_in;
            end
            if (state_q == DONE) begin
                if (!we_q) begin
                    hold_q <= rd_value;
                end else if (is_gpio && !bad_access) begin
                    gpio_out <= data_q;
                end
            end
        end
    end

`ifdef MIO_ERR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((state_q == DONE) && bad_access) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_mio_mem_responder.sv
// tb/tb_mio_mem_responder.sv - directed scoreboard bench for mio_mem_responder (WAIT_CYCLES 2 and 0)
module tb_mio_mem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gi;

    logic        re0, we0, rdy0;
    logic [31:0] a0, d0, q0, go0;
    logic        re1, we1, rdy1;
    logic [31:0] a1, d1, q1, go1;
`ifdef MIO_ERR_EN
    logic        err0, err1;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] sbq [$];

    always #5 clk = ~clk;

    mio_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(2)) u0 (
        .clk(clk), .rst(rst), .mem_re(re0), .mem_we(we0), .mem_addr(a0), .mem_data(d0),
        .mem_data_in(q0), .MIO_ready(rdy0), .gpio_in(gi), .gpio_out(go0)
`ifdef MIO_ERR_EN
        , .err(err0)
`endif
    );

    mio_mem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) u1 (
        .clk(clk), .rst(rst), .mem_re(re1), .mem_we(we1), .mem_addr(a1), .mem_data(d1),
        .mem_data_in(q1), .MIO_ready(rdy1), .gpio_in(gi), .gpio_out(go1)
`ifdef MIO_ERR_EN
        , .err(err1)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called just after a rising edge; returns just after the edge that ends DONE.
    task automatic acc0(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        int          low;
        logic        done;
        logic [31:0] exp;
        re0 = ~w; we0 = w; a0 = a; d0 = d;
        if (!w) sbq.push_back(e);
        @(negedge clk);
        chk("u0_req_cycle_ready", {31'b0, rdy0}, 32'd0);
        low  = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (rdy0) done = 1'b1;
            else      low++;
        end
        chk("u0_done_reached", {31'b0, done}, 32'd1);
        chk("u0_stall_cycles", low, 32'd2);
        if (!w) begin
            exp = (sbq.size() > 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
            chk("u0_load_data", q0, exp);
        end
        @(posedge clk); #1;
        re0 = 1'b0; we0 = 1'b0;
    endtask

    task automatic acc1(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [31:0] e);
        logic [31:0] exp;
        re1 = ~w; we1 = w; a1 = a; d1 = d;
        if (!w) sbq.push_back(e);
        @(posedge clk); #1;
        re1 = 1'b0; we1 = 1'b0;
        @(negedge clk);
        chk("u1_done_ready", {31'b0, rdy1}, 32'd1);
        if (!w) begin
            exp = (sbq.size() > 0) ? sbq.pop_front() : 32'hDEAD_BEEF;
            chk("u1_load_data", q1, exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1; gi = 32'h0;
        re0 = 1'b0; we0 = 1'b0; a0 = '0; d0 = '0;
        re1 = 1'b0; we1 = 1'b0; a1 = '0; d1 = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'b0, rdy0}, 32'd1);
        chk("rst_data", q0, 32'h0);
        chk("rst_gpio", go0, 32'h0);
`ifdef MIO_ERR_EN
        chk("rst_err", {31'b0, err0}, 32'd0);
`endif
        @(posedge clk); #1;

        acc0(1'b1, 32'h4, 32'h0000_0002, 32'h0);
        acc0(1'b0, 32'h4, 32'h0, 32'h0000_0002);
        acc0(1'b1, 32'h0, 32'h1111_0000, 32'h0);

        // back-to-back loads with one idle cycle between
        acc0(1'b0, 32'h0, 32'h0, 32'h1111_0000);
        @(negedge clk);
        chk("b2b_idle_ready", {31'b0, rdy0}, 32'd1);
        chk("b2b_hold_data", q0, 32'h1111_0000);
        @(posedge clk); #1;
        acc0(1'b0, 32'h4, 32'h0, 32'h0000_0002);

        acc0(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFE, 32'h0);
        @(negedge clk);
        chk("gpio_out", go0, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        gi = 32'hA5A5_A5A5;
        acc0(1'b0, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_A5A5);

        acc0(1'b1, 32'h8, 32'hCAFE_0008, 32'h0);
        re0 = 1'b0; we0 = 1'b1; a0 = 32'h8; d0 = 32'hDEAD_0008;
        @(posedge clk); #1;
        rst = 1'b1; we0 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midrst_ready", {31'b0, rdy0}, 32'd1);
        chk("midrst_gpio", go0, 32'h0);
        chk("midrst_data", q0, 32'h0);
        @(posedge clk); #1;
        acc0(1'b0, 32'h8, 32'h0, 32'hCAFE_0008);

        acc1(1'b1, 32'h10, 32'h5555_AAAA, 32'h0);
        acc1(1'b0, 32'h10, 32'h0, 32'h5555_AAAA);
        acc1(1'b0, 32'hFFFF_FFFC, 32'h0, 32'hA5A5_A5A5);
        acc1(1'b1, 32'hFFFF_FFFC, 32'h0000_1234, 32'h0);
        @(negedge clk);
        chk("u1_gpio_out", go1, 32'h0000_1234);
        @(posedge clk); #1;

`ifdef MIO_ERR_EN
        acc0(1'b1, 32'h6, 32'h0000_0BAD, 32'h0);
        @(negedge clk);
        chk("err_set", {31'b0, err0}, 32'd1);
        @(posedge clk); #1;
        acc0(1'b0, 32'h4, 32'h0, 32'h0000_0002);
        acc0(1'b0, 32'h1000, 32'h0, 32'h0);
        @(negedge clk);
        chk("err_sticky", {31'b0, err0}, 32'd1);
        @(posedge clk); #1;
`else
        acc0(1'b1, 32'h6, 32'h0000_0077, 32'h0);
        acc0(1'b0, 32'h4, 32'h0, 32'h0000_0077);
        acc0(1'b0, 32'h1000, 32'h0, 32'h1111_0000);
`endif

        chk("sb_empty", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mio_mem_responder.md
Name: mio_mem_responder

Overview:
- Memory-side responder for the PCPU data port: the other end of the CPU's mem_we/mem_addr/mem_data/mem_data_in/MIO_ready interface.
- Holds a word RAM and one memory-mapped GPIO word, and inserts a programmable number of wait states.
- Deasserts MIO_ready so the CPU stalls its pipeline until each access completes.
- Sits between PCPU and the board I/O in the top-level schematic.

Parameters:
- DEPTH, 1024, number of 32-bit RAM words (power of two).
- WAIT_CYCLES, 2, wait states per access (0..15).
- GPIO_ADDR, 32'hFFFF_FFFC, byte address of the GPIO word.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- mem_re  in  1  CPU load strobe (MEM-stage MemRead).
- mem_we  in  1  CPU store strobe.
- mem_addr  in  32  CPU byte address.
- mem_data  in  32  CPU store data.
- mem_data_in  out  32  load data returned to the CPU.
- MIO_ready  out  1  high = access complete / no stall.
- gpio_in  in  32  external input word.
- gpio_out  out  32  external output register.
- err  out  1  sticky access error (only with MIO_ERR_EN).

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values:
  - state = IDLE, mem_data_in = 0, gpio_out = 0, err = 0, wait counter = 0.
  - RAM contents are not reset.
- req = mem_re | mem_we. If both are high, the access is a write.
- States:
  - IDLE: MIO_ready = ~req (combinational). On req, latch addr, data and we, load counter = WAIT_CYCLES, then go to WAIT (or DONE if WAIT_CYCLES==0).
  - WAIT: MIO_ready = 0. Counter decrements each cycle; at 1 go to DONE.
  - DONE: MIO_ready = 1. Write commits at the DONE edge; mem_data_in holds load data throughout DONE. Next state is IDLE.
- Latency: the request cycle plus WAIT_CYCLES cycles in WAIT, then DONE; the CPU samples the result in DONE (WAIT_CYCLES+1 cycles after the request cycle).
- The CPU must hold mem_addr/mem_data/strobes stable until MIO_ready is high. The responder uses only latched copies, so changes mid-access are ignored.
- Address decode on the latched address:
  - == GPIO_ADDR: write updates gpio_out; read returns gpio_in sampled at DONE entry.
  - else: RAM word index = addr[log2(DEPTH)+1:2]; upper bits are ignored (aliasing).
- mem_data_in keeps its last value outside DONE; it is not cleared.
- Back-to-back accesses: a request present in the cycle after DONE (IDLE) starts a new access. There is no IDLE-skip.
- Reset mid-access: the access is aborted, no write commits, and the block returns to IDLE with MIO_ready = 1.
- Wait counter is 4 bits wide; WAIT_CYCLES > 15 is illegal (elaboration error).

Optional Feature:
- Macro MIO_ERR_EN.
- Defined:
  - A latched address with addr[1:0] != 0 is an error: the write is suppressed and the read returns 32'h0.
  - Any address with addr[31:log2(DEPTH)+2] != 0 that is not GPIO_ADDR is also an error (unmapped), with the same handling.
  - Either error sets err at the DONE edge; err stays set until rst.
- Undefined:
  - addr[1:0] is ignored and aliasing is allowed.
  - The err port is absent.

Decomposition:
- Package mio_pkg holds:
  - the state enum (IDLE, WAIT, DONE);
  - GPIO_ADDR_DEFAULT;
  - WAIT_W = 4.
- Sub-module mio_word_ram: single-port synchronous RAM (DEPTH x 32, write-enable, read data registered). Its one-cycle read latency is absorbed by issuing the read on the WAIT-to-DONE transition.
- If WAIT_CYCLES==0, the RAM read is issued in IDLE on req.

Test Plan:
- Reset, then sw data 32'h0000_0002 to addr 32'h0000_0004 with WAIT_CYCLES=2 → MIO_ready low exactly 2 cycles, high in DONE; a following lw from 32'h0000_0004 returns 32'h0000_0002.
- sw 32'hFFFF_FFFE to 32'hFFFF_FFFC → gpio_out = 32'hFFFF_FFFE after DONE. With gpio_in = 32'hA5A5_A5A5, lw from 32'hFFFF_FFFC returns 32'hA5A5_A5A5.
- WAIT_CYCLES=0 instance → MIO_ready never low for an access; lw data is valid in the cycle after the request.
- Assert rst while in WAIT during sw to 32'h8 → RAM word 2 is unchanged, MIO_ready = 1, gpio_out = 0.
- With MIO_ERR_EN, sw to 32'h0000_0006 → no write, err = 1 and sticky. lw from 32'h0000_1000 (DEPTH=1024) → returns 0, err stays 1.
- Back-to-back lw/lw to 32'h0 and 32'h4 → two separate stall windows separated by one IDLE cycle, with correct data for each.
